countdown_16: RTL and testbench

- Loadable 4-bit down-counter sequencer with a start/ready/done handshake.
- Paced by the same enable used by the processor's up-counting iteration counters.
- Gives multi-cycle units (multdiv, coin-dispense timing) a programmable countdown of 0..15 steps, with a one-cycle done pulse at terminal count.
- Consumer-side counterpart to the free-running up-counter: starts at a loaded value, counts toward zero, and reports completion.

---
 rtl/countdown_16.sv | 107 ++++++++++
 tb/tb_countdown_16.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_16.sv
// Loadable down-counter sequencer with a start/ready/done handshake, paced by en.
// Optional auto-reload of the last accepted load value: define COUNTDOWN_16_AUTORELOAD_EN.
module countdown_16 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
`ifdef COUNTDOWN_16_AUTORELOAD_EN
    input  logic             reload,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] q_s;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
    logic [WIDTH-1:0] store_r;
    logic [WIDTH-1:0] store_s;
`endif

    // Next-state and next-count decode
    always_comb begin
        state_s = state_r;
        q_s     = q;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
        store_s = store_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A zero load skips RUN but still produces a done pulse
                    q_s     = load_val;
                    state_s = (load_val == ZERO) ? ST_DONE : ST_RUN;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
                    store_s = load_val;
`endif
                end else if (state_r == ST_DONE) begin
`ifdef COUNTDOWN_16_AUTORELOAD_EN
                    if (reload) begin
                        q_s     = store_r;
                        state_s = (store_r == ZERO) ? ST_DONE : ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // RUN always leaves at 1 -> 0, so q never wraps
                if (en) begin
                    q_s     = q - ONE;
                    state_s = (q == ONE) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                q_s     = ZERO;
            end
        endcase
    end

    // State, count and decoded handshake outputs, all registered
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            q       <= ZERO;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
            store_r <= ZERO;
`endif
        end else begin
            state_r <= state_s;
            q       <= q_s;
            ready   <= (state_s != ST_RUN);
            busy    <= (state_s == ST_RUN);
            done    <= (state_s == ST_DONE);
`ifdef COUNTDOWN_16_AUTORELOAD_EN
            store_r <= store_s;
`endif
        end
    end

endmodule

// File: tb/tb_countdown_16.sv
// Randomized plus directed self-checking bench for countdown_16 against a behavioural model.
module tb_countdown_16;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [3:0] load_val;
    logic       en;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
    logic       reload;
`endif
    logic [3:0] q;
    logic       ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: count value, activity (0 idle, 1 counting, 2 finished), remembered load
    int m_q     = 0;
    int m_mode  = 0;
    int m_store = 0;

    countdown_16 #(.WIDTH(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .load_val (load_val),
        .en       (en),
`ifdef COUNTDOWN_16_AUTORELOAD_EN
        .reload   (reload),
`endif
        .q        (q),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        bit rl;
        rl = 1'b0;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
        rl = reload;
`endif
        if (clr) begin
            m_q = 0; m_mode = 0; m_store = 0;
        end else if (m_mode != 1 && start) begin
            m_q = int'(load_val);
            m_store = m_q;
            m_mode = (m_q == 0) ? 2 : 1;
        end else if (m_mode == 1) begin
            if (en) begin
                m_q = m_q - 1;
                if (m_q == 0) m_mode = 2;
            end
        end else if (m_mode == 2) begin
            if (rl) begin
                m_q = m_store;
                m_mode = (m_store == 0) ? 2 : 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("q",     int'(q),     m_q);
        check("ready", int'(ready), (m_mode != 1) ? 1 : 0);
        check("busy",  int'(busy),  (m_mode == 1) ? 1 : 0);
        check("done",  int'(done),  (m_mode == 2) ? 1 : 0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; load_val = 4'd0; en = 1'b1;
`ifdef COUNTDOWN_16_AUTORELOAD_EN
        reload = 1'b0;
`endif
        #2;
        cycle();
        cycle();
        check("reset_q", int'(q), 0);
        check("reset_ready", int'(ready), 1);
        clr = 1'b0;
        cycle();

        // Load 5, en steady
        start = 1'b1; load_val = 4'd5; cycle();
        check("load5_q", int'(q), 5);
        start = 1'b0;
        for (int i = 0; i < 7; i++) cycle();

        // Load 3 with en toggling
        start = 1'b1; load_val = 4'd3; en = 1'b1; cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = (i % 2 == 0) ? 1'b1 : 1'b0;
            cycle();
        end
        check("en_toggle_done", int'(done), 1);
        en = 1'b1;
        cycle();

        // Zero-length countdown
        start = 1'b1; load_val = 4'd0; cycle();
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        start = 1'b0;
        cycle(); cycle();

        // Back-to-back restart in DONE
        start = 1'b1; load_val = 4'd2; cycle();
        start = 1'b0; cycle(); cycle();
        check("b2b_first_done", int'(done), 1);
        start = 1'b1; load_val = 4'd4; cycle();
        check("b2b_reload_q", int'(q), 4);
        start = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // start ignored in RUN, then clr mid-RUN
        start = 1'b1; load_val = 4'd12; cycle();
        load_val = 4'd9;
        for (int i = 0; i < 5; i++) cycle();
        check("ignored_start_q", int'(q), 7);
        start = 1'b0; clr = 1'b1; cycle();
        check("clr_run_q", int'(q), 0);
        check("clr_run_done", int'(done), 0);
        clr = 1'b0; cycle();

        // Maximum load
        start = 1'b1; load_val = 4'd15; cycle();
        start = 1'b0;
        for (int i = 0; i < 17; i++) cycle();

`ifdef COUNTDOWN_16_AUTORELOAD_EN
        start = 1'b1; load_val = 4'd3; reload = 1'b1; cycle();
        start = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        reload = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        start = 1'b1; load_val = 4'd0; reload = 1'b1; cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        reload = 1'b0; cycle(); cycle();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            clr      = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 2) == 0);
            en       = ($urandom_range(0, 3) != 0);
            load_val = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
`ifdef COUNTDOWN_16_AUTORELOAD_EN
            reload   = ($urandom_range(0, 2) == 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
